// File: rtl/bus_mem_responder.sv
// Single-port word memory behind a simple valid/ready bus: one transaction at a
// time, fixed response latency, registered responses with error signalling.
module bus_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  input  logic        BUS_rready,
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  output logic [31:0] BUS_rdata,
  output logic        BUS_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          mode_q, err_q;
  logic          latch, resp_go, mem_we, req_err;
  logic          wready_nxt, rvalid_nxt, err_nxt;
  logic [31:0]   rdata_nxt;
  logic [31:0]   mem [DEPTH];

  // BASE_ADDR is aligned to the region size, so range check is an upper-bit match
  assign req_err = (BUS_addr[1:0] != 2'b00) ||
                   (BUS_addr[31:AW+2] != BASE_ADDR[31:AW+2]);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch      = 1'b0;
    resp_go    = 1'b0;
    wready_nxt = 1'b0;
    rvalid_nxt = BUS_rvalid;
    rdata_nxt  = BUS_rdata;
    case (state)
      IDLE: if (BUS_valid) begin
        latch     = 1'b1;
        cnt_nxt   = LAT;
        state_nxt = WAIT;
      end
      WAIT: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else begin
              resp_go   = 1'b1;
              state_nxt = RESP;
            end
      RESP: if (mode_q || BUS_rready) begin
        rvalid_nxt = 1'b0;
        state_nxt  = HOLD;
      end
      HOLD: if (!BUS_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (resp_go) begin
      if (mode_q) wready_nxt = 1'b1;
      else begin
        rvalid_nxt = 1'b1;
        rdata_nxt  = err_q ? 32'hFFFF_FFFF : mem[idx_q];
      end
    end
    err_nxt = (wready_nxt | rvalid_nxt) & err_q;
    mem_we  = resp_go & mode_q & ~err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'h0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      BUS_wready <= 1'b0;
      BUS_rvalid <= 1'b0;
      BUS_rdata  <= 32'h0;
      BUS_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      BUS_wready <= wready_nxt;
      BUS_rvalid <= rvalid_nxt;
      BUS_rdata  <= rdata_nxt;
      BUS_err    <= err_nxt;
      if (latch) begin
        idx_q   <= BUS_addr[AW+1:2];
        wdata_q <= BUS_wdata;
        mode_q  <= BUS_mode;
        err_q   <= req_err;
      end
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench: driver pushes model-predicted responses, monitor pops on
// every wready/rvalid and checks data, error flag, latency and handshake.
module tb_bus_mem_responder;
  localparam int          L     = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    bit          wr;
    bit          err;
    bit          chk_data;
    logic [31:0] data;
    int          issue;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] BUS_addr = 32'h0, BUS_wdata = 32'h0;
  logic BUS_mode = 1'b0, BUS_valid = 1'b0, BUS_rready = 1'b0;
  logic BUS_wready, BUS_rvalid, BUS_err;
  logic [31:0] BUS_rdata;

  logic [31:0] a0 = 32'h0, w0 = 32'h0;
  logic m0 = 1'b0, v0 = 1'b0, rr0 = 1'b0;
  logic wr0, rv0, er0;
  logic [31:0] rd0;

  bus_mem_responder #(.DEPTH(DEPTH), .LATENCY(L), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata),
    .BUS_mode(BUS_mode), .BUS_valid(BUS_valid), .BUS_rready(BUS_rready),
    .BUS_wready(BUS_wready), .BUS_rvalid(BUS_rvalid), .BUS_rdata(BUS_rdata),
    .BUS_err(BUS_err));

  bus_mem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .clk(clk), .rst_n(rst_n), .BUS_addr(a0), .BUS_wdata(w0),
    .BUS_mode(m0), .BUS_valid(v0), .BUS_rready(rr0),
    .BUS_wready(wr0), .BUS_rvalid(rv0), .BUS_rdata(rd0), .BUS_err(er0));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, n_wready = 0;
  exp_t q[$];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: flat byte-address map, error by range/alignment rule.
  function automatic exp_t model(input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, input int issue);
    exp_t e;
    longint a = longint'(addr);
    e.wr = wr; e.issue = issue; e.chk_data = 1'b0; e.data = 32'h0;
    e.err = (addr[1:0] != 2'b00) || (a < longint'(BASE)) ||
            (a >= longint'(BASE) + 4 * DEPTH);
    if (wr) begin
      if (!e.err) ref_mem[addr] = wd;
    end else if (e.err) begin
      e.chk_data = 1'b1; e.data = 32'hFFFF_FFFF;
    end else if (ref_mem.exists(addr)) begin
      e.chk_data = 1'b1; e.data = ref_mem[addr];
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  bit in_read = 1'b0, hs_pending = 1'b0, prev_wready = 1'b0;
  exp_t mon_e, cur;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_read = 1'b0; hs_pending = 1'b0; prev_wready = 1'b0;
    end else begin
      if (BUS_wready) begin
        n_wready++;
        chk("wready_single_cycle", 32'(prev_wready), 0);
        chk("wready_rvalid_exclusive", 32'(BUS_rvalid), 0);
        chk("resp_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("resp_is_write", 32'(mon_e.wr), 1);
          chk("write_err", 32'(BUS_err), 32'(mon_e.err));
          chk("write_latency", 32'(cyc - mon_e.issue), L + 1);
        end
      end else if (hs_pending) begin
        chk("rvalid_drop_after_handshake", 32'(BUS_rvalid), 0);
        hs_pending = 1'b0; in_read = 1'b0;
      end else if (BUS_rvalid) begin
        if (!in_read) begin
          chk("resp_expected", 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            cur = q.pop_front();
            chk("resp_is_read", 32'(cur.wr), 0);
            chk("read_err", 32'(BUS_err), 32'(cur.err));
            chk("read_latency", 32'(cyc - cur.issue), L + 1);
            if (cur.chk_data) chk("rdata", BUS_rdata, cur.data);
          end
          in_read = 1'b1;
        end else begin
          if (cur.chk_data) chk("rdata_held", BUS_rdata, cur.data);
          chk("err_held", 32'(BUS_err), 32'(cur.err));
        end
        if (BUS_rready) hs_pending = 1'b1;
      end else begin
        if (in_read) begin
          chk("rvalid_held_until_rready", 32'(BUS_rvalid), 1);
          in_read = 1'b0;
        end
        chk("err_idle", 32'(BUS_err), 0);
      end
      prev_wready = BUS_wready;
    end
  end

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int rr_delay, input int hold, input bit drop_early);
    int t, n0;
    @(posedge clk); #1;
    BUS_valid = 1'b1; BUS_mode = wr; BUS_addr = addr; BUS_wdata = wd;
    BUS_rready = (rr_delay == 0);
    n0 = n_wready;
    q.push_back(model(wr, addr, wd, cyc + 1));
    @(posedge clk); #1;
    BUS_addr = $urandom; BUS_wdata = $urandom;
    if (drop_early) begin
      BUS_valid = 1'b0; BUS_mode = 1'($urandom_range(0, 1));
    end
    t = 0;
    while (!(BUS_wready || BUS_rvalid) && t < 40) begin @(posedge clk); #1; t++; end
    chk("resp_timeout", 32'(BUS_wready | BUS_rvalid), 1);
    if (!wr) begin
      repeat (rr_delay) begin @(posedge clk); #1; end
      BUS_rready = 1'b1;
      t = 0;
      while (BUS_rvalid && t < 10) begin @(posedge clk); #1; t++; end
      chk("rvalid_timeout", 32'(BUS_rvalid), 0);
    end
    repeat (hold) begin @(posedge clk); #1; end
    if (wr && hold > 0) chk("held_request_one_wready", 32'(n_wready - n0), 1);
    BUS_valid = 1'b0; BUS_rready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    logic [31:0] ad;
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r;
    logic [31:0] ad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wready", 32'(BUS_wready), 0);
    chk("reset_rvalid", 32'(BUS_rvalid), 0);
    chk("reset_err", 32'(BUS_err), 0);
    chk("reset_rdata", BUS_rdata, 0);
    rst_n = 1'b1;

    // LATENCY=0 instance: response right after the edge following the sample
    @(posedge clk); #1; v0 = 1; m0 = 1; a0 = 32'h1008; w0 = 32'hCAFE_0008;
    @(posedge clk); #1; v0 = 0; chk("l0_wready_early", 32'(wr0), 0);
    @(posedge clk); #1; chk("l0_wready", 32'(wr0), 1); chk("l0_w_err", 32'(er0), 0);
    @(posedge clk); #1; chk("l0_wready_drop", 32'(wr0), 0);
    @(posedge clk); #1; v0 = 1; m0 = 0; a0 = 32'h1008; rr0 = 1;
    @(posedge clk); #1; v0 = 0; chk("l0_rvalid_early", 32'(rv0), 0);
    @(posedge clk); #1; chk("l0_rvalid", 32'(rv0), 1); chk("l0_rdata", rd0, 32'hCAFE_0008);
    chk("l0_r_err", 32'(er0), 0);
    @(posedge clk); #1; chk("l0_rvalid_drop", 32'(rv0), 0);
    @(posedge clk); #1; v0 = 1; a0 = 32'h0000_0FFC;
    @(posedge clk); #1; v0 = 0;
    @(posedge clk); #1; chk("l0_err_rvalid", 32'(rv0), 1);
    chk("l0_err_rdata", rd0, 32'hFFFF_FFFF); chk("l0_err_flag", 32'(er0), 1);
    @(posedge clk); #1; chk("l0_err_clear", 32'(er0), 0); rr0 = 0;

    // Directed cases on the main instance
    txn(1, 32'h10, 32'hA5A5_0001, 0, 0, 0);
    txn(0, 32'h10, 32'h0, 0, 0, 0);
    txn(0, 32'h10, 32'h0, 5, 0, 0);
    txn(1, 32'h13, 32'h1111_2222, 0, 0, 1);
    txn(0, 32'h10, 32'h0, 0, 0, 0);
    txn(0, BASE + 4 * DEPTH, 32'h0, 2, 0, 0);
    txn(1, 32'h14, 32'h0BAD_F00D, 0, 20, 0);
    txn(1, 32'h20, 32'h1234_5678, 0, 0, 1);

    // Reset while a write to 0x20 is still counting down
    @(posedge clk); #1; BUS_valid = 1; BUS_mode = 1; BUS_addr = 32'h20; BUS_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; BUS_valid = 0;
    @(posedge clk); #1; rst_n = 0; #1;
    chk("rst_wait_wready", 32'(BUS_wready), 0);
    chk("rst_wait_err", 32'(BUS_err), 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1;

    // Reset while a read is held by backpressure: outputs clear immediately
    @(posedge clk); #1; BUS_valid = 1; BUS_mode = 0; BUS_addr = 32'h20; BUS_rready = 0;
    q.push_back(model(0, 32'h20, 32'h0, cyc + 1));
    @(posedge clk); #1; BUS_valid = 0;
    t = 0;
    while (!BUS_rvalid && t < 20) begin @(posedge clk); #1; t++; end
    chk("rst_read_resp_seen", 32'(BUS_rvalid), 1);
    @(negedge clk); #1; rst_n = 0; #1;
    chk("rst_resp_rvalid", 32'(BUS_rvalid), 0);
    chk("rst_resp_rdata", BUS_rdata, 0);
    chk("rst_resp_err", 32'(BUS_err), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    txn(0, 32'h20, 32'h0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      ad = 32'(4 * $urandom_range(0, 31));
      else if (r == 7) ad = 32'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
      else if (r == 8) ad = BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 100));
      else             ad = $urandom;
      txn(1'($urandom_range(0, 1)), ad, $urandom, $urandom_range(0, 4),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
